// File: rtl/jogo_pkg.sv
// Shared game-core types: enemy state encoding, screen size, frame-tick divider and the per-axis bounce step.
// Pure declarations; no timing or flow control of its own.
package jogo_pkg;

  typedef enum logic [1:0] {
    ATIVO    = 2'd0,
    ATINGIDO = 2'd1,
    MORTO    = 2'd2
  } estado_t;

  localparam int LARGURA_TELA  = 640;
  localparam int ALTURA_TELA   = 480;
  localparam int DIV_TICK_60HZ = 833333;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;   // 1 = moving towards larger coordinates
  } passo_t;

  // One tick of movement on one axis; sums are widened to 11 bits so they never wrap.
  function automatic passo_t passo(input logic [9:0] pos, input logic dir,
                                   input logic [9:0] vel, input logic [9:0] min,
                                   input logic [9:0] lim);
    passo_t r;
    r.pos = pos;
    r.dir = dir;
    if (dir) begin
      if (({1'b0, pos} + {1'b0, vel}) > {1'b0, lim}) begin
        r.pos = lim;
        r.dir = 1'b0;
      end else begin
        r.pos = pos + vel;
      end
    end else begin
      if ({1'b0, pos} < ({1'b0, min} + {1'b0, vel})) begin
        r.pos = min;
        r.dir = 1'b1;
      end else begin
        r.pos = pos - vel;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gerador_tick.sv
// Frame-tick generator: one-cycle tick every DIV cycles, combinational from the count register.
// pausa holds the count and masks the tick; limpar restarts the count from zero.
module gerador_tick import jogo_pkg::*; #(
  parameter int DIV = DIV_TICK_60HZ
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic pausa,
  input  logic limpar,
  output logic tick
);

  localparam int             W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   ULTIMO = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == ULTIMO) && !pausa;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (limpar)
      cnt <= '0;
    else if (!pausa)
      cnt <= (cnt == ULTIMO) ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/inimigo_movel.sv
// Enemy sprite controller: bouncing movement, hit points, invulnerability flash and respawn; 1-edge registered outputs.
// No backpressure: pausa freezes tick-driven behaviour and masks acerto, reiniciarJogo overrides everything.
module inimigo_movel import jogo_pkg::*; #(
  parameter int LARGURA       = 30,
  parameter int ALTURA        = 30,
  parameter int X_INICIAL     = 300,
  parameter int Y_INICIAL     = 300,
  parameter int X_MIN         = 0,
  parameter int X_MAX         = LARGURA_TELA - 1,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = ALTURA_TELA - 1,
  parameter int VEL_X         = 2,
  parameter int VEL_Y         = 1,
  parameter int DIV_TICK      = DIV_TICK_60HZ,
  parameter int VIDA          = 3,
  parameter int TICKS_PISCA   = 30,
  parameter int TICKS_RESPAWN = 120
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       acerto,
  output logic [9:0] largura,
  output logic [9:0] altura,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visivel,
  output logic       vivo,
  output logic       destruido,
  output logic [3:0] vida
);

  localparam logic [9:0] XLIM = 10'(X_MAX - LARGURA + 1);
  localparam logic [9:0] YLIM = 10'(Y_MAX - ALTURA + 1);

  logic        tick;
  estado_t     estado;
  logic        dir_x, dir_y;
  logic [15:0] cnt_pisca, cnt_respawn;
  logic [1:0]  fase;
  passo_t      px, py;

  gerador_tick #(.DIV(DIV_TICK)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .pausa    (pausa),
    .limpar   (reiniciarJogo),
    .tick     (tick)
  );

  assign largura = 10'(LARGURA);
  assign altura  = 10'(ALTURA);
  assign px      = passo(x, dir_x, 10'(VEL_X), 10'(X_MIN), XLIM);
  assign py      = passo(y, dir_y, 10'(VEL_Y), 10'(Y_MIN), YLIM);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado <= ATIVO;      x <= 10'(X_INICIAL);   y <= 10'(Y_INICIAL);
      dir_x <= 1'b1;        dir_y <= 1'b1;         vida <= 4'(VIDA);
      visivel <= 1'b1;      vivo <= 1'b1;          destruido <= 1'b0;
      cnt_pisca <= '0;      cnt_respawn <= '0;     fase <= '0;
    end else if (reiniciarJogo) begin
      estado <= ATIVO;      x <= 10'(X_INICIAL);   y <= 10'(Y_INICIAL);
      dir_x <= 1'b1;        dir_y <= 1'b1;         vida <= 4'(VIDA);
      visivel <= 1'b1;      vivo <= 1'b1;          destruido <= 1'b0;
      cnt_pisca <= '0;      cnt_respawn <= '0;     fase <= '0;
    end else begin
      destruido <= 1'b0;
      case (estado)
        ATIVO: begin
          if (tick) begin
            x <= px.pos;  dir_x <= px.dir;
            y <= py.pos;  dir_y <= py.dir;
          end
          if (acerto && !pausa) begin
            visivel <= 1'b0;
            if (vida > 4'd1) begin
              vida      <= vida - 4'd1;
              estado    <= ATINGIDO;
              cnt_pisca <= 16'(TICKS_PISCA);
              fase      <= '0;
            end else begin
              // A fatal hit on a tick edge still keeps the move taken above.
              vida        <= '0;
              estado      <= MORTO;
              vivo        <= 1'b0;
              destruido   <= 1'b1;
              cnt_respawn <= 16'(TICKS_RESPAWN);
            end
          end
        end
        ATINGIDO: begin
          if (tick) begin
            x <= px.pos;  dir_x <= px.dir;
            y <= py.pos;  dir_y <= py.dir;
            fase <= fase + 2'd1;
            if (fase == 2'd3)
              visivel <= ~visivel;
            if (cnt_pisca <= 16'd1) begin
              estado    <= ATIVO;
              visivel   <= 1'b1;
              cnt_pisca <= '0;
            end else begin
              cnt_pisca <= cnt_pisca - 16'd1;
            end
          end
        end
        MORTO: begin
          if (tick) begin
            if (cnt_respawn <= 16'd1) begin
              estado      <= ATIVO;
              x           <= 10'(X_INICIAL);
              y           <= 10'(Y_INICIAL);
              dir_x       <= 1'b1;
              dir_y       <= 1'b1;
              vida        <= 4'(VIDA);
              visivel     <= 1'b1;
              vivo        <= 1'b1;
              cnt_respawn <= '0;
            end else begin
              cnt_respawn <= cnt_respawn - 16'd1;
            end
          end
        end
        default: estado <= ATIVO;
      endcase
    end
  end

endmodule

// File: tb/tb_inimigo_movel.sv
// Bench for inimigo_movel: a centre instance plus one spawned near the right/bottom limits.
// Expected observations are queued as stimulus is applied and popped when the outputs are sampled.
module tb_inimigo_movel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, pausa, reiniciar, acerto;
  logic [9:0] larg, alt, x, y, larg_b, alt_b, x_b, y_b;
  logic       vis, vivo, destr, vis_b, vivo_b, destr_b;
  logic [3:0] vida, vida_b;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       vivo;
    logic       destr;
    logic [3:0] vida;
  } obs_t;

  obs_t obs, obs_b;
  assign obs   = {x, y, vis, vivo, destr, vida};
  assign obs_b = {x_b, y_b, vis_b, vivo_b, destr_b, vida_b};

  obs_t fila[$];
  obs_t fila_b[$];
  int   total  = 0;
  int   passed = 0;
  int   m_x, m_y;

  inimigo_movel #(
    .DIV_TICK(4), .VEL_X(2), .VEL_Y(1), .VIDA(2), .TICKS_PISCA(8), .TICKS_RESPAWN(5)
  ) u_dut (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciar), .acerto(acerto),
    .largura(larg), .altura(alt), .x(x), .y(y), .visivel(vis), .vivo(vivo),
    .destruido(destr), .vida(vida)
  );

  // XLIM = 639-30+1 = 610, YLIM = 479-30+1 = 450
  inimigo_movel #(
    .X_INICIAL(607), .Y_INICIAL(449),
    .DIV_TICK(4), .VEL_X(2), .VEL_Y(1), .VIDA(2), .TICKS_PISCA(8), .TICKS_RESPAWN(5)
  ) u_borda (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciar), .acerto(1'b0),
    .largura(larg_b), .altura(alt_b), .x(x_b), .y(y_b), .visivel(vis_b), .vivo(vivo_b),
    .destruido(destr_b), .vida(vida_b)
  );

  function automatic obs_t mk(int px, int py, bit pv, bit pvivo, bit pd, int pvida);
    return {10'(px), 10'(py), pv, pvivo, pd, 4'(pvida)};
  endfunction

  task automatic ciclos(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b0; pausa = 1'b0; reiniciar = 1'b0; acerto = 1'b0;
    m_x = 300; m_y = 300;
    fila.push_back(mk(300, 300, 1, 1, 0, 2));
    fila_b.push_back(mk(607, 449, 1, 1, 0, 2));
    ciclos(2);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL reset: got %p want %p", obs, e); else passed++;
    e = fila_b.pop_front(); total++;
    if (obs_b !== e) $display("FAIL reset_borda: got %p want %p", obs_b, e); else passed++;
    total++;
    if ({larg, alt} !== {10'd30, 10'd30})
      $display("FAIL dimensoes: got %0d x %0d want 30 x 30", larg, alt);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_movimento();
    obs_t e;
    int bx[3] = '{609, 610, 608};
    int by[3] = '{450, 450, 449};
    fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
    ciclos(3);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL antes_tick: got %p want %p", obs, e); else passed++;
    for (int k = 0; k < 3; k++) begin
      m_x += 2; m_y += 1;
      fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
      fila_b.push_back(mk(bx[k], by[k], 1, 1, 0, 2));
      ciclos(k == 0 ? 1 : 4);
      e = fila.pop_front(); total++;
      if (obs !== e) $display("FAIL mov_%0d: got %p want %p", k, obs, e); else passed++;
      e = fila_b.pop_front(); total++;
      if (obs_b !== e) $display("FAIL borda_%0d: got %p want %p", k, obs_b, e); else passed++;
    end
  endtask

  task automatic test_pausa();
    obs_t e;
    fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
    ciclos(3);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL pre_pausa: got %p want %p", obs, e); else passed++;
    // Count sits at its last value: the tick is due on the very next edge.
    pausa = 1'b1;
    fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
    ciclos(10);
    acerto = 1'b1;
    ciclos(1);
    acerto = 1'b0;
    ciclos(9);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL pausa: got %p want %p", obs, e); else passed++;
    pausa = 1'b0;
    m_x += 2; m_y += 1;
    fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
    ciclos(1);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL pos_pausa: got %p want %p", obs, e); else passed++;
  endtask

  task automatic test_acerto();
    obs_t e;
    acerto = 1'b1;
    fila.push_back(mk(m_x, m_y, 0, 1, 0, 1));
    ciclos(1);
    acerto = 1'b0;
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL acerto: got %p want %p", obs, e); else passed++;
    for (int t = 1; t <= 8; t++) begin
      if (t == 2) begin
        acerto = 1'b1; ciclos(1); acerto = 1'b0; ciclos(3);
      end else begin
        ciclos(t == 1 ? 3 : 4);
      end
      m_x += 2; m_y += 1;
      fila.push_back(mk(m_x, m_y, (t >= 4), 1, 0, 1));
      e = fila.pop_front(); total++;
      if (obs !== e) $display("FAIL pisca_%0d: got %p want %p", t, obs, e); else passed++;
    end
  endtask

  task automatic test_fatal();
    obs_t e;
    ciclos(3);
    acerto = 1'b1;
    ciclos(1);
    acerto = 1'b0;
    m_x += 2; m_y += 1;
    fila.push_back(mk(m_x, m_y, 0, 0, 1, 0));
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL fatal: got %p want %p", obs, e); else passed++;
    fila.push_back(mk(m_x, m_y, 0, 0, 0, 0));
    ciclos(1);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL destruido_pulso: got %p want %p", obs, e); else passed++;
    for (int t = 1; t <= 5; t++) begin
      if (t == 3) begin
        acerto = 1'b1; ciclos(1); acerto = 1'b0; ciclos(3);
      end else begin
        ciclos(t == 1 ? 3 : 4);
      end
      if (t < 5) begin
        fila.push_back(mk(m_x, m_y, 0, 0, 0, 0));
      end else begin
        m_x = 300; m_y = 300;
        fila.push_back(mk(300, 300, 1, 1, 0, 2));
      end
      e = fila.pop_front(); total++;
      if (obs !== e) $display("FAIL respawn_%0d: got %p want %p", t, obs, e); else passed++;
    end
    m_x += 2; m_y += 1;
    fila.push_back(mk(m_x, m_y, 1, 1, 0, 2));
    ciclos(4);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL dir_respawn: got %p want %p", obs, e); else passed++;
  endtask

  task automatic test_reinicio();
    obs_t e;
    acerto = 1'b1; ciclos(1); acerto = 1'b0;
    ciclos(31);
    m_x += 16; m_y += 8;
    acerto = 1'b1;
    fila.push_back(mk(m_x, m_y, 0, 0, 1, 0));
    ciclos(1);
    acerto = 1'b0;
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL morto_pre_reinicio: got %p want %p", obs, e); else passed++;
    ciclos(1);
    reiniciar = 1'b1; acerto = 1'b1; pausa = 1'b1;
    fila.push_back(mk(300, 300, 1, 1, 0, 2));
    fila_b.push_back(mk(607, 449, 1, 1, 0, 2));
    ciclos(1);
    reiniciar = 1'b0; acerto = 1'b0; pausa = 1'b0;
    m_x = 300; m_y = 300;
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL reinicio: got %p want %p", obs, e); else passed++;
    e = fila_b.pop_front(); total++;
    if (obs_b !== e) $display("FAIL reinicio_borda: got %p want %p", obs_b, e); else passed++;
    fila.push_back(mk(300, 300, 1, 1, 0, 2));
    ciclos(3);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL reinicio_sem_tick: got %p want %p", obs, e); else passed++;
    fila.push_back(mk(302, 301, 1, 1, 0, 2));
    ciclos(1);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL reinicio_tick: got %p want %p", obs, e); else passed++;
    m_x = 302; m_y = 301;
  endtask

  task automatic test_reset_meio();
    obs_t e;
    ciclos(3);
    acerto = 1'b1;
    ciclos(1);
    acerto = 1'b0;
    m_x += 2; m_y += 1;
    fila.push_back(mk(m_x, m_y, 0, 1, 0, 1));
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL atingido_tick: got %p want %p", obs, e); else passed++;
    ciclos(4);
    m_x += 2; m_y += 1;
    fila.push_back(mk(m_x, m_y, 0, 1, 0, 1));
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL atingido_mov: got %p want %p", obs, e); else passed++;
    #2 reset = 1'b0;
    fila.push_back(mk(300, 300, 1, 1, 0, 2));
    #1;
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL reset_assincrono: got %p want %p", obs, e); else passed++;
    @(negedge clk);
    reset = 1'b1;
    fila.push_back(mk(302, 301, 1, 1, 0, 2));
    ciclos(4);
    e = fila.pop_front(); total++;
    if (obs !== e) $display("FAIL pos_reset: got %p want %p", obs, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_movimento();
    test_pausa();
    test_acerto();
    test_fatal();
    test_reinicio();
    test_reset_meio();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
